// File: rtl/slc3_mem_pkg.sv
// rtl/slc3_mem_pkg.sv - shared types and defaults for the SLC-3 memory controller
package slc3_mem_pkg;
  localparam int WORD_W         = 16;
  localparam int MEM_WORDS_DEF  = 256;
  localparam int INIT_WORDS_DEF = 64;

  typedef enum logic [1:0] {
    INIT_ROM = 2'd0,
    INIT_CLR = 2'd1,
    READY    = 2'd2
  } state_t;
endpackage

// File: rtl/slc3_ram_1p.sv
// rtl/slc3_ram_1p.sv - single-port synchronous RAM with registered read
module slc3_ram_1p
  import slc3_mem_pkg::*;
#(
  parameter int DEPTH = MEM_WORDS_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/slc3_mem_ctrl.sv
// rtl/slc3_mem_ctrl.sv - loads RAM from program ROM, clears the tail, then serves CPU reads/writes
module slc3_mem_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int MEM_WORDS  = MEM_WORDS_DEF,
  parameter int INIT_WORDS = INIT_WORDS_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       ADDR,
  input  logic              OE,
  input  logic              WE,
  input  logic [WORD_W-1:0] Data_to_SRAM,
  output logic [WORD_W-1:0] Data_from_SRAM,
  output logic [15:0]       Rom_Addr,
  input  logic [WORD_W-1:0] Rom_Data,
  output logic              Init_Done,
  output logic              Err
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = AW + 1;

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic              in_range;
  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;
  logic              zero_rd;

  assign in_range = (ADDR < 16'(MEM_WORDS));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= INIT_ROM;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt leads the RAM write address by one because ROM data arrives a cycle late
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      INIT_ROM: begin
        cnt_next = cnt + 1'b1;
        if (cnt == CW'(INIT_WORDS))
          state_next = (INIT_WORDS == MEM_WORDS) ? READY : INIT_CLR;
      end
      INIT_CLR: begin
        cnt_next = cnt + 1'b1;
        if (cnt == CW'(MEM_WORDS)) state_next = READY;
      end
      READY:   state_next = READY;
      default: state_next = INIT_ROM;
    endcase
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = ADDR[AW-1:0];
    ram_wdata = Data_to_SRAM;
    Rom_Addr  = '0;
    Init_Done = 1'b0;
    case (state)
      INIT_ROM: begin
        ram_we    = (cnt != '0);
        ram_addr  = AW'(cnt - 1'b1);
        ram_wdata = Rom_Data;
        if (cnt < CW'(INIT_WORDS)) Rom_Addr = 16'(cnt);
      end
      INIT_CLR: begin
        ram_we    = 1'b1;
        ram_addr  = AW'(cnt - 1'b1);
        ram_wdata = '0;
      end
      READY: begin
        Init_Done = 1'b1;
        ram_we    = WE && !OE && in_range;
        ram_re    = OE && !WE && in_range;
      end
      default: ;
    endcase
  end

  // zero_rd masks the RAM output register during init and after out-of-range reads
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Err     <= 1'b0;
      zero_rd <= 1'b1;
    end else begin
      if (state == READY && (OE || WE) && ((OE && WE) || !in_range)) Err <= 1'b1;
      if (state != READY) zero_rd <= 1'b1;
      else if (OE && !WE) zero_rd <= !in_range;
    end
  end

  assign Data_from_SRAM = zero_rd ? '0 : ram_rdata;

  slc3_ram_1p #(.DEPTH(MEM_WORDS), .AW(AW)) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// tb/tb_slc3_mem_ctrl.sv - randomized self-checking bench for slc3_mem_ctrl against a behavioural model
module tb_slc3_mem_ctrl;
  localparam int MEMW  = 256;
  localparam int INITW = 64;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] ADDR = '0;
  logic        OE = 1'b0;
  logic        WE = 1'b0;
  logic [15:0] Data_to_SRAM = '0;
  logic [15:0] Data_from_SRAM;
  logic [15:0] Rom_Addr;
  logic [15:0] Rom_Data = '0;
  logic        Init_Done;
  logic        Err;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_mem [MEMW];
  logic [15:0] m_dout;
  logic        m_err;
  logic        m_done;
  int          m_cyc;

  slc3_mem_ctrl #(.MEM_WORDS(MEMW), .INIT_WORDS(INITW)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ADDR           (ADDR),
    .OE             (OE),
    .WE             (WE),
    .Data_to_SRAM   (Data_to_SRAM),
    .Data_from_SRAM (Data_from_SRAM),
    .Rom_Addr       (Rom_Addr),
    .Rom_Data       (Rom_Data),
    .Init_Done      (Init_Done),
    .Err            (Err)
  );

  always #5 Clk = ~Clk;

  // program ROM: data for an address appears one cycle after it is presented
  always @(posedge Clk) Rom_Data <= 16'hA000 + Rom_Addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [15:0] exp_rom;
    exp_rom = (!m_done && m_cyc < INITW) ? 16'(m_cyc) : 16'h0;
    chk("dout", 32'(Data_from_SRAM), 32'(m_dout));
    chk("err", 32'(Err), 32'(m_err));
    chk("init_done", 32'(Init_Done), 32'(m_done));
    chk("rom_addr", 32'(Rom_Addr), 32'(exp_rom));
  endtask

  task automatic model_edge(input logic oe, input logic we, input logic [15:0] a, input logic [15:0] d);
    logic valid;
    valid = (a < 16'(MEMW));
    if (!m_done) begin
      m_cyc++;
      m_dout = '0;
      if (m_cyc == MEMW + 1) begin
        m_done = 1'b1;
        for (int k = 0; k < MEMW; k++) m_mem[k] = (k < INITW) ? 16'(16'hA000 + k) : 16'h0;
      end
    end else if (oe && we) begin
      m_err = 1'b1;
    end else if (we) begin
      if (valid) m_mem[a[7:0]] = d;
      else m_err = 1'b1;
    end else if (oe) begin
      if (valid) m_dout = m_mem[a[7:0]];
      else begin
        m_dout = '0;
        m_err  = 1'b1;
      end
    end
  endtask

  task automatic step(input logic oe, input logic we, input logic [15:0] a, input logic [15:0] d);
    OE = oe; WE = we; ADDR = a; Data_to_SRAM = d;
    model_edge(oe, we, a, d);
    @(posedge Clk);
    @(negedge Clk);
    compare_all();
  endtask

  task automatic apply_reset(input int n);
    Reset = 1'b0;
    OE = 1'b0; WE = 1'b0;
    #1;
    m_cyc = 0; m_done = 1'b0; m_err = 1'b0; m_dout = '0;
    compare_all();
    repeat (n) @(negedge Clk);
    compare_all();
    Reset = 1'b1;
  endtask

  task automatic run_init(output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      if (Init_Done) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int r;
    logic [15:0] a;
    m_cyc = 0; m_done = 1'b0; m_err = 1'b0; m_dout = '0;
    @(negedge Clk);
    apply_reset(3);
    chk("reset_dout", 32'(Data_from_SRAM), 32'h0);

    run_init(n);
    chk("init_cycles", n, 257);

    step(1'b1, 1'b0, 16'h0003, 16'h0);
    chk("rd3", 32'(Data_from_SRAM), 32'hA003);
    step(1'b0, 1'b0, 16'h0003, 16'h0);
    step(1'b0, 1'b0, 16'h0007, 16'h0);
    chk("rd3_hold", 32'(Data_from_SRAM), 32'hA003);
    step(1'b1, 1'b0, 16'h0005, 16'h0);
    chk("rd5", 32'(Data_from_SRAM), 32'hA005);
    step(1'b1, 1'b0, 16'h0040, 16'h0);
    chk("rd64", 32'(Data_from_SRAM), 32'h0);
    step(1'b1, 1'b0, 16'h0005, 16'h0);
    step(1'b1, 1'b0, 16'h00FF, 16'h0);
    chk("rd255", 32'(Data_from_SRAM), 32'h0);

    step(1'b0, 1'b1, 16'h0010, 16'h1234);
    step(1'b1, 1'b0, 16'h0010, 16'h0);
    chk("raw", 32'(Data_from_SRAM), 32'h1234);
    chk("raw_err", 32'(Err), 32'h0);

    step(1'b1, 1'b1, 16'h0002, 16'hFFFF);
    chk("both_err", 32'(Err), 32'h1);
    chk("both_hold", 32'(Data_from_SRAM), 32'h1234);
    step(1'b1, 1'b0, 16'h0002, 16'h0);
    chk("rd2_kept", 32'(Data_from_SRAM), 32'hA002);
    step(1'b1, 1'b0, 16'h0100, 16'h0);
    chk("oor_rd", 32'(Data_from_SRAM), 32'h0);
    step(1'b0, 1'b0, 16'h0000, 16'h0);
    chk("err_sticky", 32'(Err), 32'h1);

    a = 16'h0;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 2) != 0) a = 16'($urandom_range(0, MEMW - 1));
      case (r)
        0, 1, 2, 3: step(1'b1, 1'b0, a, 16'h0);
        4, 5, 6:    step(1'b0, 1'b1, a, 16'($urandom));
        7:          step(1'b0, 1'b0, a, 16'($urandom));
        8:          step(1'($urandom_range(0, 1)), 1'b1, 16'($urandom_range(MEMW, 16'hFFFF)), 16'($urandom));
        default:    step(1'b1, 1'b1, a, 16'($urandom));
      endcase
    end

    apply_reset(2);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
    apply_reset(2);
    chk("rom_restart0", 32'(Rom_Addr), 32'h0);
    chk("reinit_err", 32'(Err), 32'h0);
    step(1'b1, 1'b1, 16'h0001, 16'h5555);
    chk("rom_restart1", 32'(Rom_Addr), 32'h1);
    run_init(n);
    chk("reinit_cycles", n + 1, 257);
    chk("reinit_err_done", 32'(Err), 32'h0);

    for (int k = 0; k < MEMW; k++) step(1'b1, 1'b0, 16'(k), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
